// File: rtl/fifo_stream_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// fifo_stream_pkg : shared types and constants for the FIFO read streamer
// Rev 1.0
// ------------------------------------------------------------------
package fifo_stream_pkg;

  typedef enum logic [1:0] {
    OCC0 = 2'd0,
    OCC1 = 2'd1,
    OCC2 = 2'd2
  } occ_t;

  localparam int STAT_CNT_W = 32;
  localparam int SKID_DEPTH = 2;

  function automatic logic [STAT_CNT_W-1:0] sat_inc(input logic [STAT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_skid_buf.sv
`default_nettype none
// ------------------------------------------------------------------
// stream_skid_buf : 2-entry in-order buffer, head always in entry 0
// Rev 1.0
// ------------------------------------------------------------------
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int FIFO_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [FIFO_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output occ_t                  o_occ,
  output logic [FIFO_WIDTH-1:0] o_head
);

  occ_t                  r_occ;
  occ_t                  w_occ_nxt;
  logic [FIFO_WIDTH-1:0] r_ent [SKID_DEPTH];
  logic [FIFO_WIDTH-1:0] w_ent [SKID_DEPTH];

  always_comb begin
    w_occ_nxt = r_occ;
    w_ent     = r_ent;
    case (r_occ)
      OCC0: begin
        if (i_push) begin
          w_ent[0]  = i_push_data;
          w_occ_nxt = OCC1;
        end
      end
      OCC1: begin
        case ({i_push, i_pop})
          2'b10: begin
            w_ent[1]  = i_push_data;
            w_occ_nxt = OCC2;
          end
          2'b01:   w_occ_nxt = OCC0;
          2'b11:   w_ent[0]  = i_push_data;
          default: w_occ_nxt = OCC1;
        endcase
      end
      OCC2: begin
        // The second entry moves up to become the new head on every pop.
        if (i_pop) begin
          w_ent[0] = r_ent[1];
          if (i_push) w_ent[1] = i_push_data;
          else        w_occ_nxt = OCC1;
        end
      end
      default: w_occ_nxt = OCC0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= OCC0;
      r_ent <= '{default: '0};
    end else begin
      r_occ <= w_occ_nxt;
      r_ent <= w_ent;
    end
  end

  always @(posedge clk) begin
    if (rst_n) assert (!(i_push && !i_pop && (r_occ == OCC2)));
  end

  assign o_occ  = r_occ;
  assign o_head = r_ent[0];

endmodule
`default_nettype wire

// File: rtl/fifo_rd_streamer.sv
`default_nettype none
// ------------------------------------------------------------------
// fifo_rd_streamer : drains a synchronous FIFO into a valid/ready stream
// Optional counters: define FIFO_RD_STREAMER_STATS_EN. Rev 1.0
// ------------------------------------------------------------------
module fifo_rd_streamer
  import fifo_stream_pkg::*;
#(
  parameter int FIFO_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  err_underflow
`ifdef FIFO_RD_STREAMER_STATS_EN
  ,
  output logic [STAT_CNT_W-1:0] word_cnt,
  output logic [STAT_CNT_W-1:0] stall_cnt
`endif
);

  occ_t       w_occ;
  logic       w_pop;
  logic [2:0] w_level;
  logic       r_inflight;
  logic       r_err;

  assign w_pop   = m_valid & m_ready;
  // Words buffered or in flight after this edge; a new read needs a free slot.
  assign w_level = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign fifo_rd_en = rst_n & en & ~fifo_empty & (w_level < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_inflight <= fifo_rd_en;
      r_err      <= r_err | fifo_underflow;
    end
  end

  stream_skid_buf #(
    .FIFO_WIDTH (FIFO_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_inflight),
    .i_push_data (fifo_data_out),
    .i_pop       (w_pop),
    .o_occ       (w_occ),
    .o_head      (m_data)
  );

  assign m_valid       = (w_occ != OCC0);
  assign err_underflow = r_err;

`ifdef FIFO_RD_STREAMER_STATS_EN
  logic [STAT_CNT_W-1:0] r_word_cnt;
  logic [STAT_CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_pop)                r_word_cnt  <= sat_inc(r_word_cnt);
      if (m_valid && !m_ready)  r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign word_cnt  = r_word_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_streamer.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_fifo_rd_streamer : directed bench with a behavioural FIFO and scoreboard
// Rev 1.0
// ------------------------------------------------------------------
module tb_fifo_rd_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        m_ready;
  logic        inj_uf;
  logic        fifo_rd_en;
  logic        m_valid;
  logic [15:0] m_data;
  logic        err_underflow;
  logic        fifo_empty;
  logic        fifo_underflow;
  logic        model_uf = 1'b0;
  logic [15:0] fifo_data_out = '0;
`ifdef FIFO_RD_STREAMER_STATS_EN
  logic [31:0] word_cnt;
  logic [31:0] stall_cnt;
`endif

  logic [15:0] mem [4096];
  logic [11:0] wptr = '0;
  logic [11:0] rptr = '0;
  logic [15:0] exp_q [$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_rd_streamer #(
    .FIFO_WIDTH (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .fifo_data_out  (fifo_data_out),
    .fifo_rd_en     (fifo_rd_en),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .err_underflow  (err_underflow)
`ifdef FIFO_RD_STREAMER_STATS_EN
    ,
    .word_cnt       (word_cnt),
    .stall_cnt      (stall_cnt)
`endif
  );

  // Synchronous FIFO model: one-cycle read latency, registered underflow.
  assign fifo_empty     = (wptr == rptr);
  assign fifo_underflow = model_uf | inj_uf;

  always @(posedge clk) begin
    model_uf <= 1'b0;
    if (fifo_rd_en) begin
      if (wptr != rptr) begin
        fifo_data_out <= mem[rptr];
        rptr          <= rptr + 12'd1;
      end else begin
        model_uf <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] d);
    mem[wptr] = d;
    wptr      = wptr + 12'd1;
    exp_q.push_back(d);
  endtask

  // mode: 0 = ready low, 1 = ready high, 2 = random ready
  task automatic run(input int n, input int mode, output int rd, output int hs);
    logic        prev_stall;
    logic [15:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    rd = 0;
    hs = 0;
    for (int i = 0; i < n; i++) begin
      m_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
      #1;
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1'b1);
        chk("hold_data", m_data, prev_data);
      end
      if (fifo_rd_en) rd++;
      if (m_valid && m_ready) begin
        hs++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL extra_word: observed %0h expected none", m_data);
        end else begin
          chk("m_data", m_data, exp_q.pop_front());
        end
      end
      prev_stall = m_valid & ~m_ready;
      prev_data  = m_data;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rd, hs, rd_tot, guard;
    rst_n   = 1'b0;
    en      = 1'b1;
    m_ready = 1'b1;
    inj_uf  = 1'b0;
    for (int i = 1; i <= 8; i++) push(16'(i));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 16'h0000);
    chk("rst_err", err_underflow, 1'b0);
    chk("rst_rd_en", fifo_rd_en, 1'b0);
    rst_n = 1'b1;

    // Full-rate drain of 8 preloaded words.
    for (int c = 0; c < 12; c++) begin
      #1;
      chk("t1_rd_en", fifo_rd_en, (c < 8));
      chk("t1_m_valid", m_valid, (c >= 2 && c < 10));
      if (m_valid && exp_q.size() > 0) chk("t1_m_data", m_data, exp_q.pop_front());
      @(posedge clk);
      #1;
    end
    chk("t1_err", err_underflow, 1'b0);

    // Backpressure: only two reads outstanding, head held.
    for (int i = 1; i <= 8; i++) push(16'(i));
    run(6, 0, rd, hs);
    chk("bp_rd_cnt", rd, 2);
    chk("bp_hs_cnt", hs, 0);
    #1;
    chk("bp_m_valid", m_valid, 1'b1);
    chk("bp_m_data", m_data, 16'h0001);
    chk("bp_rd_en", fifo_rd_en, 1'b0);
    run(16, 1, rd, hs);
    chk("bp_rd_rest", rd, 6);
    chk("bp_hs_rest", hs, 8);
    chk("bp_left", exp_q.size(), 0);

    // Random ready over 1000 words.
    for (int i = 0; i < 1000; i++) push(16'($urandom));
    rd_tot = 0;
    guard  = 0;
    while (exp_q.size() > 0 && guard < 6000) begin
      run(1, 2, rd, hs);
      rd_tot += rd;
      guard++;
    end
    chk("rnd_left", exp_q.size(), 0);
    chk("rnd_rd_cnt", rd_tot, 1000);
    run(3, 1, rd, hs);
    chk("rnd_m_valid", m_valid, 1'b0);
    chk("rnd_err", err_underflow, 1'b0);

    // Single word then empty.
    push(16'hABCD);
    run(6, 1, rd, hs);
    chk("one_rd_cnt", rd, 1);
    chk("one_hs_cnt", hs, 1);
    chk("one_m_valid", m_valid, 1'b0);
    chk("one_err", err_underflow, 1'b0);

    // en dropped with one word buffered and one in flight.
    push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
    run(2, 1, rd, hs);
    chk("en_rd_pre", rd, 2);
    en = 1'b0;
    run(8, 1, rd, hs);
    chk("en_rd_off", rd, 0);
    chk("en_hs_off", hs, 2);
    chk("en_m_valid", m_valid, 1'b0);
    chk("en_left", exp_q.size(), 2);
    en = 1'b1;
    run(8, 1, rd, hs);
    chk("en_hs_resume", hs, 2);
    chk("en_left_end", exp_q.size(), 0);

    // Sticky underflow flag.
    chk("uf_before", err_underflow, 1'b0);
    inj_uf = 1'b1;
    @(posedge clk);
    #1;
    inj_uf = 1'b0;
    chk("uf_set", err_underflow, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("uf_sticky", err_underflow, 1'b1);

    // Asynchronous reset with two words buffered.
    push(16'hA001); push(16'hA002); push(16'hA003); push(16'hA004);
    run(4, 0, rd, hs);
    chk("ar_rd_cnt", rd, 2);
    chk("ar_m_valid", m_valid, 1'b1);
    chk("ar_m_data", m_data, 16'hA001);
    rst_n = 1'b0;
    #1;
    chk("ar_async_valid", m_valid, 1'b0);
    chk("ar_async_data", m_data, 16'h0000);
    chk("ar_async_err", err_underflow, 1'b0);
    chk("ar_async_rd_en", fifo_rd_en, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());

    // Five pops, then three stall cycles.
    push(16'hB001); push(16'hB002); push(16'hB003);
    run(8, 1, rd, hs);
    chk("st_hs_cnt", hs, 5);
    push(16'hC001);
    run(2, 0, rd, hs);
    run(3, 0, rd, hs);
    chk("st_m_valid", m_valid, 1'b1);
`ifdef FIFO_RD_STREAMER_STATS_EN
    chk("st_word_cnt", word_cnt, 32'd5);
    chk("st_stall_cnt", stall_cnt, 32'd3);
`endif
    run(4, 1, rd, hs);
    chk("st_hs_last", hs, 1);
    chk("st_left", exp_q.size(), 0);
`ifdef FIFO_RD_STREAMER_STATS_EN
    chk("st_word_cnt_end", word_cnt, 32'd6);
    chk("st_stall_cnt_end", stall_cnt, 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_rd_streamer.md
Name: fifo_rd_streamer

Overview:
- Read-side drain stage sitting directly downstream of the synchronous FIFO.
- Pops the FIFO through its rd_en/data_out/empty/underflow port set and presents the words as a valid/ready stream to the next consumer.
- Absorbs the FIFO's 1-cycle read latency in a 2-entry skid buffer. Sustains 1 word/clk with ready held high, and never issues a read into an empty FIFO.

Parameters:
- FIFO_WIDTH, 16, data word width; must match the FIFO's FIFO_WIDTH.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  issue enable; low stops new pops, in-flight and buffered data still drain.
- fifo_empty  input  1  FIFO empty flag.
- fifo_underflow  input  1  FIFO underflow flag (read attempted while empty).
- fifo_data_out  input  FIFO_WIDTH  FIFO read data, valid the cycle after rd_en is accepted.
- fifo_rd_en  output  1  FIFO read strobe (combinational).
- m_valid  output  1  stream data valid.
- m_ready  input  1  downstream ready.
- m_data  output  FIFO_WIDTH  stream data (oldest buffered word).
- err_underflow  output  1  sticky error flag.

Behaviour:
- Clock/reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - occ=0, inflight=0, both skid entries=0.
  - m_valid=0, m_data=0, err_underflow=0.
  - fifo_rd_en=0 while rst_n low.
- State:
  - occ in {OCC0, OCC1, OCC2}: number of buffered words.
  - inflight bit: a read was issued last cycle and its data is due this cycle.
- pop = m_valid & m_ready (handshake; the word transfers on this edge).
- fifo_rd_en = en & !fifo_empty & ((occ + inflight - pop) < 2). Evaluated combinationally in the same cycle.
- inflight <= fifo_rd_en.
- Capture: when inflight=1, fifo_data_out is written into the skid tail that same edge.
- occ_next = occ + inflight - pop. This never exceeds 2 by construction; an overflow is an assertion failure.
- Ordering is strict FIFO. m_data = head entry. On pop with occ=2, entry1 shifts to entry0.
- m_valid = (occ != 0). There is no combinational bypass from fifo_data_out to m_data, so latency from rd_en to m_valid is 2 cycles.
- Throughput: steady state occ=1, inflight=1, pop=1 issues a read every cycle (100%).
- Backpressure: with m_ready low, at most 2 words are outstanding, then fifo_rd_en drops. Data, valid and order are held stable while m_valid & !m_ready.
- en low mid-stream: no new rd_en. The in-flight word is still captured and all buffered words drain normally.
- fifo_empty rising while inflight=1: the in-flight word is still captured (it was read before empty).
- Underflow guard: fifo_underflow sampled high sets err_underflow. It stays set until rst_n.
- Reset mid-operation: in-flight and buffered words are discarded; outputs return to reset values asynchronously.

Optional Feature:
- Macro: FIFO_RD_STREAMER_STATS_EN.
- Defined: adds output ports word_cnt[31:0] and stall_cnt[31:0], both reset to 0.
  - word_cnt increments on each pop.
  - stall_cnt increments each cycle with m_valid & !m_ready.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package fifo_stream_pkg:
  - typedef enum logic [1:0] {OCC0, OCC1, OCC2} occ_t
  - localparam STAT_CNT_W = 32
  - localparam SKID_DEPTH = 2
- One sub-module, stream_skid_buf: the 2-entry ordered buffer with push/pop/occ; parameterised by FIFO_WIDTH.
- The top level holds the issue logic, the inflight bit, the error flag and the optional stats.

Test Plan:
- Reset, en=1, m_ready=1, FIFO preloaded 8 words 16'h0001..16'h0008 -> rd_en high 8 consecutive cycles. First m_valid 2 clks after first rd_en; m_data 0001..0008 back-to-back; no underflow.
- m_ready=0 with 8 words queued -> exactly 2 rd_en pulses, then rd_en=0. m_data holds 0001 stable. Raising m_ready delivers 0001,0002,0003... with no loss or duplication.
- Random m_ready (50%) over 1000 words -> output sequence equals input sequence; occ never >2; err_underflow=0.
- FIFO holding 1 word (16'hABCD) -> single rd_en; fifo_empty then high; no further rd_en; m_data=ABCD for one handshake, then m_valid=0.
- en dropped while inflight=1 and occ=1 -> no new rd_en; both buffered words (2) delivered; then m_valid=0.
- rst_n pulsed low while occ=2 -> m_valid=0 and m_data=0 immediately (asynchronous). With STATS_EN, 5 pops then 3 stall cycles -> word_cnt=5, stall_cnt=3.
